// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types, defaults and helpers
package spart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_sync2.sv
// rtl/spart_sync2.sv - two-flop synchronizer with parameterised reset value
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 oversampling receiver with rda/ferr/ovr flags
// SPART_RX_MAJORITY_EN selects 2-of-3 voting around each bit centre.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE,
  parameter int DATA_BITS  = SPART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 sample_enable,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
`ifdef SPART_RX_MAJORITY_EN
  // Decisions land one tick after the centre so the third vote is the live sample.
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
`endif

  logic                 rxd_s;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [TW-1:0]        dec_cnt;
  logic                 dec_hit;
  logic                 bit_val;

  spart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign dec_cnt = (state_q == START) ? START_DEC : TICK_LAST;
  assign dec_hit = sample_enable && (tick_cnt_q == dec_cnt);

`ifdef SPART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  assign bit_val = maj3(maj_q[0], maj_q[1], rxd_s);

  always_comb begin
    maj_d = maj_q;
    if (sample_enable && (tick_cnt_q == dec_cnt - TW'(2))) maj_d[0] = rxd_s;
    if (sample_enable && (tick_cnt_q == dec_cnt - TW'(1))) maj_d[1] = rxd_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end
`else
  assign bit_val = rxd_s;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rda_d      = rda_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    if (clr_rda) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sample_enable && !rxd_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (dec_hit) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = bit_val ? IDLE : DATA;
        end else if (sample_enable) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (dec_hit) begin
          tick_cnt_d = '0;
          shreg_d    = {bit_val, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sample_enable) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (dec_hit) begin
          tick_cnt_d = '0;
          if (bit_val) begin
            // A read in the same clock consumed the old byte, so no overrun.
            rx_data_d = shreg_q;
            rda_d     = 1'b1;
            ferr_d    = 1'b0;
            ovr_d     = rda_q & ~clr_rda;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else if (sample_enable) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      BRK: begin
        if (sample_enable && rxd_s) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rda     = rda_q;
  assign ferr    = ferr_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - directed self-checking bench for spart_rx
module tb_spart_rx;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rxd = 1'b1;
  logic       sample_enable;
  logic       clr_rda = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int errors = 0;
  int unsigned div_cnt = 0;

`ifdef SPART_RX_MAJORITY_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  spart_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .sample_enable (sample_enable),
    .clr_rda       (clr_rda),
    .rx_data       (rx_data),
    .rda           (rda),
    .ferr          (ferr),
    .ovr           (ovr)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, 16 ticks per bit -> 64 clocks per bit.
  initial begin
    sample_enable = 1'b0;
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt + 1) % 4;
      sample_enable = (div_cnt == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      rxd = (glitch && c >= 32 && c < 36) ? ~v : v;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit glitch);
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    send_bits(b, glitch);
    drive_bit(stop, glitch);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rda = 1'b1;
    @(negedge clk);
    clr_rda = 1'b0;
  endtask

  initial begin
    int  n;
    bit  found;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rda", rda, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);

    // Test 2: start glitch of 3 ticks is rejected
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (640) @(negedge clk);
    chk("t2_state", dut.state_q, IDLE);
    chk("t2_rda", rda, 1'b0);
    chk("t2_ferr", ferr, 1'b0);

    // Test 1: basic byte, with rda latency tied to a tick
    send_bits(8'hA5, GL);
    @(negedge clk);
    rxd = 1'b1;
    n = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (rda === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("t1_rda_window", (n >= 33 && n <= 44), 1'b1);
    chk("t1_rda_on_tick", sample_enable, 1'b1);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_ferr", ferr, 1'b0);
    chk("t1_ovr", ovr, 1'b0);
    repeat (40) @(negedge clk);
    pulse_clr();
    chk("t1_clr_rda", rda, 1'b0);

    // Test 3: framing error, line held low, then recovery
    send_bits(8'h3C, GL);
    @(negedge clk);
    rxd = 1'b0;
    repeat (159) @(negedge clk);
    chk("t3_ferr", ferr, 1'b1);
    chk("t3_rda", rda, 1'b0);
    chk("t3_rx_hold", rx_data, 8'hA5);
    chk("t3_state_brk", dut.state_q, BRK);
    @(negedge clk);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    chk("t3_ferr_sticky", ferr, 1'b1);
    send_frame(8'h81, 1'b1, GL);
    chk("t3_rx_data", rx_data, 8'h81);
    chk("t3_rda", rda, 1'b1);
    chk("t3_ferr_clear", ferr, 1'b0);

    // Test 4: overrun
    pulse_clr();
    send_frame(8'h11, 1'b1, GL);
    chk("t4_first_ovr", ovr, 1'b0);
    send_frame(8'h22, 1'b1, GL);
    chk("t4_rx_data", rx_data, 8'h22);
    chk("t4_rda", rda, 1'b1);
    chk("t4_ovr", ovr, 1'b1);
    pulse_clr();
    chk("t4_clr_rda", rda, 1'b0);
    chk("t4_clr_ovr", ovr, 1'b0);
    pulse_clr();
    chk("t4_idle_clr_rda", rda, 1'b0);
    chk("t4_idle_clr_rx", rx_data, 8'h22);

    // Test 5: clr_rda coincides with the stop-sample tick of a second byte
    send_frame(8'h33, 1'b1, GL);
    chk("t5_first_rda", rda, 1'b1);
    send_bits(8'h44, GL);
    @(negedge clk);
    rxd = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (dut.state_q == STOP && dut.tick_cnt_q == 4'd15) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_found_stop", found, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (sample_enable === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_found_tick", found, 1'b1);
    clr_rda = 1'b1;
    @(negedge clk);
    clr_rda = 1'b0;
    chk("t5_rda", rda, 1'b1);
    chk("t5_ovr", ovr, 1'b0);
    chk("t5_rx_data", rx_data, 8'h44);
    repeat (64) @(negedge clk);

    // Test 6: async reset during bit 4 of 0xFF
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    repeat (30) @(negedge clk);
    chk("t6_mid_data", dut.state_q, DATA);
    chk("t6_pre_rda", rda, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rx_data", rx_data, 8'h00);
    chk("t6_rst_rda", rda, 1'b0);
    chk("t6_rst_ferr", ferr, 1'b0);
    chk("t6_rst_ovr", ovr, 1'b0);
    chk("t6_rst_state", dut.state_q, IDLE);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    send_frame(8'h5A, 1'b1, GL);
    chk("t6_rx_data", rx_data, 8'h5A);
    chk("t6_rda", rda, 1'b1);
    chk("t6_ferr", ferr, 1'b0);
    chk("t6_ovr", ovr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
